// File: rtl/vocab_reader.sv
// Token-index to word streamer: walks a 0x00-terminated vocabulary SRAM to the
// token_id-th word and emits its bytes (terminator included) over valid/ready.
module vocab_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ID_WIDTH-1:0]   token_id,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  found
);

  typedef enum logic [1:0] {IDLE, SEEK, EMIT, FIN} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   remain;
  logic                  addr_end;   // the read at the top address has been issued
  logic                  vld_p1;     // mem_rdata carries the byte read last cycle
  logic                  term_seen;  // terminator of the emitted word already taken
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_vld;

  logic issue, fin_ok, fin_ovf;
  logic rd_in, rd_zero, out_free, skid_nxt;

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign rd_in    = vld_p1 && !term_seen;
  assign rd_zero  = (mem_rdata == '0);
  assign out_free = !out_valid || out_ready;
  assign skid_nxt = skid_vld ? (!out_free || rd_in) : (!out_free && rd_in);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fin_ok    = 1'b0;
    fin_ovf   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SEEK;
      SEEK: begin
        issue = !addr_end;
        if (remain == '0) begin
          state_nxt = EMIT;
        end else if (vld_p1 && rd_zero && remain == ID_WIDTH'(1)) begin
          // next word starts one past this byte; that read is issued only if it exists
          if (addr_end) fin_ovf   = 1'b1;
          else          state_nxt = EMIT;
        end else if (!vld_p1 && addr_end) begin
          fin_ovf = 1'b1;
        end
      end
      EMIT: begin
        // never issue a read whose byte could find both output and skid full
        issue = !addr_end && !term_seen && !(rd_in && rd_zero) && !skid_nxt;
        if (out_valid && out_ready && out_last)
          fin_ok = 1'b1;
        else if (addr_end && !vld_p1 && !term_seen && !skid_vld && out_free)
          fin_ovf = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fin_ok || fin_ovf) state_nxt = FIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain    <= '0;
      mem_addr  <= '0;
      addr_end  <= 1'b0;
      vld_p1    <= 1'b0;
      term_seen <= 1'b0;
      found     <= 1'b0;
    end else if (state == IDLE && start) begin
      remain    <= token_id;
      mem_addr  <= '0;
      addr_end  <= 1'b0;
      vld_p1    <= 1'b0;
      term_seen <= 1'b0;
      found     <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        if (mem_addr == {ADDR_WIDTH{1'b1}}) addr_end <= 1'b1;
        else                                mem_addr <= mem_addr + 1'b1;
      end
      if (state == SEEK && vld_p1 && rd_zero && remain != '0)
        remain <= remain - 1'b1;
      if (state == EMIT && rd_in && rd_zero)
        term_seen <= 1'b1;
      if (fin_ok)
        found <= 1'b1;
    end
  end

  // output stage: registered beat plus one-entry skid for the read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (state == EMIT) begin
      if (out_free) begin
        if (skid_vld) begin
          out_data  <= skid_data;
          out_last  <= skid_last;
          out_valid <= 1'b1;
          skid_vld  <= rd_in;
          skid_data <= mem_rdata;
          skid_last <= rd_zero;
        end else begin
          out_valid <= rd_in;
          if (rd_in) begin
            out_data <= mem_rdata;
            out_last <= rd_zero;
          end
        end
      end else if (rd_in) begin
        skid_vld  <= 1'b1;
        skid_data <= mem_rdata;
        skid_last <= rd_zero;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      skid_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vocab_reader.sv
// Directed bench for vocab_reader against a small behavioural vocabulary SRAM.
module tb_vocab_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] token_id;
  logic       busy;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       done;
  logic       found;

  vocab_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ID_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .token_id(token_id), .busy(busy),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .done(done), .found(found)
  );

  logic [7:0] mem [0:15];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_data [0:15];
  logic       got_last [0:15];
  int         nbeats, first_vld, done_cnt, stalls;
  logic       got_found, timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready held high; mode 1: toggling with a 3-cycle low hold
  task automatic run_req(input logic [3:0] id, input int mode, input int stop_beats);
    logic       ps;
    logic [7:0] pd;
    logic       pl;
    nbeats = 0; first_vld = -1; done_cnt = 0; stalls = 0;
    got_found = 1'b0; timeout = 1'b1; ps = 1'b0; pd = '0; pl = 1'b0;
    token_id = id;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((k >= 10 && k < 13) ? 1'b0 : k[0]);
      if (ps) begin
        stalls++;
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      if (out_valid && first_vld < 0) first_vld = k;
      if (out_valid && out_ready && nbeats < 16) begin
        got_data[nbeats] = out_data;
        got_last[nbeats] = out_last;
        nbeats++;
      end
      ps = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (done) begin
        done_cnt++;
        got_found = found;
        timeout   = 1'b0;
        break;
      end
      if (stop_beats > 0 && nbeats >= stop_beats) begin
        timeout = 1'b0;
        break;
      end
    end
    chk("timeout", timeout, 0);
  endtask

  logic [7:0] exp_d [0:3];
  logic       exp_l [0:3];
  int         dseen;

  initial begin
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h00; mem[3] = 8'h43;
    mem[4] = 8'h00; mem[5] = 8'h44; mem[6] = 8'h45; mem[7] = 8'h46;
    for (int i = 8; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; token_id = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // token 0: word "AB"
    run_req(4'd0, 0, 0);
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h00;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
    chk("t1_nbeats", nbeats, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", got_data[i], exp_d[i]);
      chk("t1_last", got_last[i], exp_l[i]);
    end
    chk("t1_first_vld", first_vld, 2);
    chk("t1_found", got_found, 1);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_found_held", found, 1);

    // token 2: word "DEF", five skipped bytes
    run_req(4'd2, 0, 0);
    exp_d[0] = 8'h44; exp_d[1] = 8'h45; exp_d[2] = 8'h46; exp_d[3] = 8'h00;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b0;  exp_l[3] = 1'b1;
    chk("t2_nbeats", nbeats, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", got_data[i], exp_d[i]);
      chk("t2_last", got_last[i], exp_l[i]);
    end
    chk("t2_first_vld", first_vld, 7);
    chk("t2_found", got_found, 1);
    @(negedge clk);

    // token 3: empty word at address 9
    run_req(4'd3, 0, 0);
    chk("t3_nbeats", nbeats, 1);
    chk("t3_data", got_data[0], 8'h00);
    chk("t3_last", got_last[0], 1);
    chk("t3_found", got_found, 1);
    @(negedge clk);

    // token 10: starts past the top of memory
    run_req(4'd10, 0, 0);
    chk("t4_nbeats", nbeats, 0);
    chk("t4_done", done_cnt, 1);
    chk("t4_found", got_found, 0);
    @(negedge clk);
    chk("t4_busy_off", busy, 0);

    // token 2 with backpressure
    run_req(4'd2, 1, 0);
    out_ready = 1'b1;
    chk("t5_nbeats", nbeats, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_data", got_data[i], exp_d[i]);
      chk("t5_last", got_last[i], exp_l[i]);
    end
    chk("t5_found", got_found, 1);
    chk("t5_stalled", stalls > 0, 1);
    @(negedge clk);

    // reset while emitting token 2
    run_req(4'd2, 0, 1);
    chk("t6_first_beat", got_data[0], 8'h44);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_found", found, 0);
    chk("t6_rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid) dseen++;
    end
    chk("t6_no_done", dseen, 0);
    run_req(4'd1, 0, 0);
    chk("t6_nbeats", nbeats, 2);
    chk("t6_data0", got_data[0], 8'h43);
    chk("t6_last0", got_last[0], 0);
    chk("t6_data1", got_data[1], 8'h00);
    chk("t6_last1", got_last[1], 1);
    chk("t6_found", got_found, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
